cpu_run_ctrl: RTL

Synthesizable run controller between the board-level clock and the CPU core. It replaces free-running clock gating with a clock-enable state machine that supports:
- a reset/boot window (for memory preload);
- free run, pause and N-cycle single-step;
- halt capture and a saturating executed-cycle counter;
- an optional watchdog.

It sits in `machine`, driving the CPU clock-enable and CPU reset, and sampling `cpu_halted` from the core.

---
 rtl/cpu_run_ctrl.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/cpu_run_ctrl.sv
// Run controller for the CPU core: clock-enable FSM with boot window, run/pause/step and halt capture.
// Define CPU_RUN_CTRL_WDOG_EN to build the watchdog that forces TIMEOUT after wdog_limit enabled cycles.
module cpu_run_ctrl #(
  parameter int CNT_W    = 32,
  parameter int STEP_W   = 16,
  parameter int WDOG_W   = 24,
  parameter int BOOT_CYC = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              stop,
  input  logic              step,
  input  logic [STEP_W-1:0] step_count,
  input  logic [WDOG_W-1:0] wdog_limit,
  input  logic              cpu_halted,
  output logic              cpu_en,
  output logic              cpu_reset,
  output logic              done,
  output logic              timeout,
  output logic [2:0]        status,
  output logic [CNT_W-1:0]  cycle_count
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_BOOT    = 3'd1;
  localparam logic [2:0] S_RUN     = 3'd2;
  localparam logic [2:0] S_STEP    = 3'd3;
  localparam logic [2:0] S_PAUSE   = 3'd4;
  localparam logic [2:0] S_HALTED  = 3'd5;
  localparam logic [2:0] S_TIMEOUT = 3'd6;

  localparam logic [7:0] BOOT_LAST = 8'(BOOT_CYC - 1);

  logic [2:0]        state;
  logic [2:0]        state_nx;
  logic              kind_step;
  logic [STEP_W-1:0] step_rem;
  logic [7:0]        boot_cnt;
  logic              step_ok;
  logic              expire;
  logic              boot_entry;
  logic              boot_exit;

  assign step_ok    = step && (step_count != '0);
  assign status     = state;
  assign boot_entry = (state_nx == S_BOOT) && (state != S_BOOT);
  assign boot_exit  = (state == S_BOOT) && (state_nx != S_BOOT);

  // Each branch lists its conditions in priority order: halt, expiry, stop, start, step.
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE, S_HALTED, S_TIMEOUT: begin
        if (start || step_ok) state_nx = S_BOOT;
      end
      S_BOOT: begin
        if (boot_cnt == BOOT_LAST) state_nx = kind_step ? S_STEP : S_RUN;
      end
      S_RUN: begin
        if (cpu_halted)  state_nx = S_HALTED;
        else if (expire) state_nx = S_TIMEOUT;
        else if (stop)   state_nx = S_PAUSE;
      end
      S_STEP: begin
        if (cpu_halted)                     state_nx = S_HALTED;
        else if (expire)                    state_nx = S_TIMEOUT;
        else if (stop)                      state_nx = S_PAUSE;
        else if (step_rem == STEP_W'(1))    state_nx = S_PAUSE;
      end
      S_PAUSE: begin
        if (cpu_halted)   state_nx = S_HALTED;
        else if (start)   state_nx = S_RUN;
        else if (step_ok) state_nx = S_STEP;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state entered at each edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      cpu_en      <= 1'b0;
      cpu_reset   <= 1'b1;
      done        <= 1'b0;
      cycle_count <= '0;
      kind_step   <= 1'b0;
      step_rem    <= '0;
      boot_cnt    <= '0;
    end else begin
      state     <= state_nx;
      cpu_en    <= (state_nx == S_RUN) || (state_nx == S_STEP);
      cpu_reset <= (state_nx == S_IDLE) || (state_nx == S_BOOT);
      done      <= (state_nx == S_HALTED) && (state != S_HALTED);
      boot_cnt  <= (state == S_BOOT) ? boot_cnt + 8'd1 : 8'd0;

      if (boot_entry) begin
        kind_step <= !start;
      end

      if (boot_entry && !start) begin
        step_rem <= step_count;
      end else if ((state == S_PAUSE) && (state_nx == S_STEP)) begin
        step_rem <= step_count;
      end else if (state == S_STEP) begin
        step_rem <= step_rem - STEP_W'(1);
      end

      if (boot_entry) begin
        cycle_count <= '0;
      end else if (cpu_en && (cycle_count != '1)) begin
        cycle_count <= cycle_count + CNT_W'(1);
      end
    end
  end

`ifdef CPU_RUN_CTRL_WDOG_EN
  logic [WDOG_W-1:0] wdog_cnt;
  logic [WDOG_W:0]   wdog_inc;

  // Expire on the edge that completes the wdog_limit-th enabled cycle, so that cycle is still counted.
  assign wdog_inc = {1'b0, wdog_cnt} + (WDOG_W + 1)'(1);
  assign expire   = ((state == S_RUN) || (state == S_STEP)) && (wdog_limit != '0) &&
                    (wdog_inc == {1'b0, wdog_limit});

  always_ff @(posedge clk) begin
    if (reset) begin
      wdog_cnt <= '0;
      timeout  <= 1'b0;
    end else begin
      if (boot_exit) begin
        wdog_cnt <= '0;
      end else if (cpu_en) begin
        wdog_cnt <= wdog_cnt + WDOG_W'(1);
      end

      if ((state_nx == S_TIMEOUT) && (state != S_TIMEOUT)) begin
        timeout <= 1'b1;
      end else if (boot_entry) begin
        timeout <= 1'b0;
      end
    end
  end
`else
  logic unused_wdog;

  assign unused_wdog = ^{wdog_limit, boot_exit};
  assign expire      = 1'b0;
  assign timeout     = 1'b0;
`endif

endmodule
